// File: rtl/min_serial_tx_pkg.sv
// Shared constants, state codes and frame-bit lookup for min_serial_tx.
// MIN_SERIAL_TX_PARITY_EN adds an even-parity bit between D7 and the stop bit.
package min_serial_tx_pkg;

    localparam int DATA_W = 8;

`ifdef MIN_SERIAL_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        TX   = 2'b10
    } state_t;

    // Index 0 is the start bit, 1..8 the data LSB first, then parity (if any), then stop.
    function automatic logic frame_bit(input logic [DATA_W-1:0] data, input logic [3:0] idx);
        logic [DATA_W-1:0] sh;
        sh = data >> (idx - 4'd1);
        if (idx == 4'd0) return 1'b0;
        if (idx <= 4'(DATA_W)) return sh[0];
`ifdef MIN_SERIAL_TX_PARITY_EN
        if (idx == 4'(DATA_W + 1)) return ^data;
`endif
        return 1'b1;
    endfunction

endpackage

// File: rtl/min_serial_tx_bit_timer.sv
// DIV-cycle down-counter for min_serial_tx: load sets DIV-1, zero flags the
// last clock of a serial bit.
module min_serial_tx_bit_timer #(
    parameter int DIV = 4
) (
    input  logic clock,
    input  logic reset_,
    input  logic load,
    output logic zero
);

    localparam logic [7:0] RELOAD = 8'(DIV - 1);

    logic [7:0] div_cnt;

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            div_cnt <= 8'd0;
        end else if (load) begin
            div_cnt <= RELOAD;
        end else if (div_cnt != 8'd0) begin
            div_cnt <= div_cnt - 8'd1;
        end
    end

    assign zero = (div_cnt == 8'd0);

endmodule

// File: rtl/min_serial_tx.sv
// Serial transmitter downstream of the minimum producer (dav_/rfd handshake).
// Optional even parity bit when MIN_SERIAL_TX_PARITY_EN is defined.
module min_serial_tx
    import min_serial_tx_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic       clock,
    input  logic       reset_,
    input  logic [7:0] min,
    input  logic       dav_,
    output logic       rfd,
    output logic       txd,
    output logic       busy
);

    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    state_t            state, state_nxt;
    logic              rfd_nxt, txd_nxt, busy_nxt;
    logic [3:0]        bit_cnt, bit_cnt_nxt;
    logic [DATA_W-1:0] shift_reg;
    logic              latch, timer_load, timer_zero;

    min_serial_tx_bit_timer #(.DIV(DIV)) u_bit_timer (
        .clock (clock),
        .reset_(reset_),
        .load  (timer_load),
        .zero  (timer_zero)
    );

    always_comb begin
        state_nxt   = state;
        rfd_nxt     = rfd;
        txd_nxt     = txd;
        busy_nxt    = busy;
        bit_cnt_nxt = bit_cnt;
        latch       = 1'b0;
        timer_load  = 1'b0;
        case (state)
            WAIT: begin
                rfd_nxt = 1'b0;
                txd_nxt = 1'b1;
                if (dav_) begin
                    state_nxt   = TX;
                    txd_nxt     = 1'b0;
                    busy_nxt    = 1'b1;
                    bit_cnt_nxt = 4'd0;
                    timer_load  = 1'b1;
                end
            end
            TX: begin
                if (timer_zero) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = IDLE;
                        rfd_nxt   = 1'b1;
                        busy_nxt  = 1'b0;
                        txd_nxt   = 1'b1;
                    end else begin
                        txd_nxt     = frame_bit(shift_reg, bit_cnt + 4'd1);
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        timer_load  = 1'b1;
                    end
                end
            end
            // Unused encoding behaves exactly like IDLE.
            default: begin
                rfd_nxt  = 1'b1;
                txd_nxt  = 1'b1;
                busy_nxt = 1'b0;
                if (!dav_) begin
                    latch     = 1'b1;
                    rfd_nxt   = 1'b0;
                    state_nxt = WAIT;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state   <= IDLE;
            rfd     <= 1'b1;
            txd     <= 1'b1;
            busy    <= 1'b0;
            bit_cnt <= 4'd0;
        end else begin
            state   <= state_nxt;
            rfd     <= rfd_nxt;
            txd     <= txd_nxt;
            busy    <= busy_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    // Data register carries no reset; it is only read after a latch.
    always_ff @(posedge clock) begin
        if (latch) shift_reg <= min;
    end

endmodule

// File: tb/tb_min_serial_tx.sv
// Randomized bench for min_serial_tx: three instances (DIV=4,2,1) checked
// against a frame-list reference model built from the byte.
module tb_min_serial_tx;

    localparam int NDUT = 3;
    localparam int DIVS [NDUT] = '{4, 2, 1};

    logic       clock = 1'b0;
    logic       reset_;
    logic [7:0] min_v  [NDUT];
    logic       dav_v  [NDUT];
    logic       rfd_v  [NDUT];
    logic       txd_v  [NDUT];
    logic       busy_v [NDUT];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        min_serial_tx #(.DIV(DIVS[g])) u_dut (
            .clock (clock),
            .reset_(reset_),
            .min   (min_v[g]),
            .dav_  (dav_v[g]),
            .rfd   (rfd_v[g]),
            .txd   (txd_v[g]),
            .busy  (busy_v[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [7:0] scramble(input bit ff_mode);
        return ff_mode ? 8'hFF : 8'($urandom);
    endfunction

    // One transfer on instance i. Called right after a negedge.
    task automatic xfer(input int i, input logic [7:0] data, input bit ff_mode,
                        input int abort_bit, input bit next_early, input logic [7:0] next_data);
        int   d;
        int   nf;
        int   waited;
        logic exp_bits [$];
        d = DIVS[i];
        exp_bits.push_back(1'b0);
        for (int b = 0; b < 8; b++) exp_bits.push_back(logic'((data >> b) & 8'd1));
`ifdef MIN_SERIAL_TX_PARITY_EN
        exp_bits.push_back(logic'($countones(data) % 2));
`endif
        exp_bits.push_back(1'b1);
        nf = exp_bits.size();

        waited = 0;
        while (rfd_v[i] !== 1'b1 && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        if (waited >= 200) begin
            check_eq("rfd_ready_wait", rfd_v[i], 1);
            return;
        end
        min_v[i] = data;
        dav_v[i] = 1'b0;
        @(negedge clock);
        check_eq("wait_rfd", rfd_v[i], 0);
        check_eq("wait_txd", txd_v[i], 1);
        check_eq("wait_busy", busy_v[i], 0);
        repeat ($urandom_range(0, 2)) begin
            min_v[i] = scramble(ff_mode);
            @(negedge clock);
            check_eq("wait_hold_rfd", rfd_v[i], 0);
            check_eq("wait_hold_txd", txd_v[i], 1);
        end
        dav_v[i] = 1'b1;
        min_v[i] = scramble(ff_mode);

        for (int k = 0; k <= nf * d; k++) begin
            @(negedge clock);
            if (k < nf * d) begin
                check_eq($sformatf("tx_bit%0d", k / d), txd_v[i], exp_bits[k / d]);
                check_eq("tx_rfd", rfd_v[i], 0);
                check_eq("tx_busy", busy_v[i], 1);
                if (abort_bit >= 0 && k == abort_bit * d + d / 2) begin
                    #2;
                    reset_ = 1'b0;
                    #1;
                    check_eq("abort_txd", txd_v[i], 1);
                    check_eq("abort_rfd", rfd_v[i], 1);
                    check_eq("abort_busy", busy_v[i], 0);
                    dav_v[i] = 1'b0;
                    min_v[i] = 8'h01;
                    repeat (2) @(negedge clock);
                    reset_ = 1'b1;
                    return;
                end
                if (k == nf * d - 1) begin
                    dav_v[i] = next_early ? 1'b0 : 1'b1;
                    min_v[i] = next_early ? next_data : scramble(ff_mode);
                end else begin
                    dav_v[i] = 1'($urandom_range(0, 1));
                    min_v[i] = scramble(ff_mode);
                end
            end else begin
                check_eq("end_rfd", rfd_v[i], 1);
                check_eq("end_busy", busy_v[i], 0);
                check_eq("end_txd", txd_v[i], 1);
            end
        end
    endtask

    initial begin
        logic [7:0] d0, d1;
        int         sel;
        bit         early;
        reset_ = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            dav_v[i] = 1'b1;
            min_v[i] = 8'h00;
        end
        repeat (3) @(negedge clock);
        for (int i = 0; i < NDUT; i++) begin
            check_eq("rst_rfd", rfd_v[i], 1);
            check_eq("rst_txd", txd_v[i], 1);
            check_eq("rst_busy", busy_v[i], 0);
        end
        reset_ = 1'b1;
        repeat (20) begin
            @(negedge clock);
            for (int i = 0; i < NDUT; i++) begin
                check_eq("idle_rfd", rfd_v[i], 1);
                check_eq("idle_txd", txd_v[i], 1);
                check_eq("idle_busy", busy_v[i], 0);
            end
        end

        xfer(0, 8'hA5, 1'b0, -1, 1'b0, 8'h00);
        xfer(0, 8'h3C, 1'b1, -1, 1'b0, 8'h00);
        xfer(1, 8'h07, 1'b0, -1, 1'b0, 8'h00);
        xfer(0, 8'h5A, 1'b0, 4, 1'b0, 8'h00);
        xfer(0, 8'h01, 1'b0, -1, 1'b0, 8'h00);
        xfer(2, 8'h00, 1'b0, -1, 1'b0, 8'h00);
        xfer(2, 8'hFF, 1'b0, -1, 1'b0, 8'h00);
        xfer(2, 8'h81, 1'b0, -1, 1'b1, 8'h42);
        xfer(2, 8'h42, 1'b0, -1, 1'b0, 8'h00);

        for (int r = 0; r < 12; r++) begin
            sel   = $urandom_range(0, NDUT - 1);
            d0    = 8'($urandom);
            d1    = 8'($urandom);
            early = 1'($urandom_range(0, 1));
            xfer(sel, d0, 1'b0, -1, early, d1);
            if (early) xfer(sel, d1, 1'b0, -1, 1'b0, 8'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
